// File: rtl/enemy_spawn_scheduler.sv
// Per-game-tick sequencer: spawns enemies into free slots, strobes move/damage
// to all slots and grants one enemy attack per tick by round-robin arbitration.
module enemy_spawn_scheduler #(
    parameter int SPAWN_PERIOD = 8,
    parameter int MIN_PERIOD   = 2,
    parameter int WAVE_SIZE    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_tick,
    input  logic        enable,
    input  logic [3:0]  slot_alive,
    input  logic [31:0] slot_damage,
    output logic [3:0]  spawn_req,
    output logic        move_scen,
    output logic        damage_scen,
    output logic        attack_valid,
    output logic [1:0]  attack_slot,
    output logic [7:0]  attack_dmg,
    output logic [7:0]  wave_num,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SPAWN  = 3'd1;
    localparam logic [2:0] MOVE   = 3'd2;
    localparam logic [2:0] DAMAGE = 3'd3;
    localparam logic [2:0] ATTACK = 3'd4;

    localparam logic [7:0] PERIOD_INIT = 8'(SPAWN_PERIOD);
    localparam logic [7:0] PERIOD_MIN  = 8'(MIN_PERIOD);
    localparam logic [2:0] WAVE_LAST   = 3'(WAVE_SIZE);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] per;
    logic [2:0] spawn_cnt;
    logic [1:0] rr;
    logic       accept;

    logic       free_found;
    logic [1:0] free_idx;
    logic [3:0] cand;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] probe;
    logic [7:0] win_dmg;

    assign accept = (state == IDLE) && game_tick && enable;
    assign busy   = (state != IDLE);

    // Lowest-index free slot; the downward scan lets the lowest index win.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!slot_alive[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        cand = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cand[i] = slot_alive[i] && (slot_damage[8*i +: 8] != 8'd0);
        end
    end

    // Round-robin search from rr upward; scanning offsets high-to-low leaves
    // the nearest candidate to rr as the final assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr;
        probe     = rr;
        for (int k = 3; k >= 0; k--) begin
            probe = rr + 2'(k);
            if (cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    assign win_dmg = slot_damage[{win_idx, 3'b000} +: 8];

    // Sequence FSM: IDLE waits for an accepted tick, every other state is one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SPAWN;
                SPAWN:   state <= MOVE;
                MOVE:    state <= DAMAGE;
                DAMAGE:  state <= ATTACK;
                ATTACK:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Any tick that lands on a busy sequencer is lost; remember it until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (game_tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Spawn pacing and wave progression, evaluated once per accepted tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= PERIOD_INIT;
            per       <= PERIOD_INIT;
            spawn_cnt <= 3'd0;
            wave_num  <= 8'd0;
            spawn_req <= 4'b0000;
        end else begin
            spawn_req <= 4'b0000;
            if (accept) begin
                if (cnt <= 8'd1) begin
                    if (free_found) begin
                        spawn_req <= 4'b0001 << free_idx;
                        cnt       <= per;
                        if (spawn_cnt + 3'd1 == WAVE_LAST) begin
                            spawn_cnt <= 3'd0;
                            if (wave_num != 8'hFF) wave_num <= wave_num + 8'd1;
                            if (per > PERIOD_MIN)  per      <= per - 8'd1;
                        end else begin
                            spawn_cnt <= spawn_cnt + 3'd1;
                        end
                    end else begin
                        // Parking at zero keeps the spawn due for the next tick.
                        cnt <= 8'd0;
                    end
                end else begin
                    cnt <= cnt - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_scen   <= 1'b0;
            damage_scen <= 1'b0;
        end else begin
            move_scen   <= (state == SPAWN);
            damage_scen <= (state == MOVE);
        end
    end

    // Attack grant is sampled on the edge leaving DAMAGE and shown during ATTACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attack_valid <= 1'b0;
            attack_slot  <= 2'd0;
            attack_dmg   <= 8'd0;
            rr           <= 2'd0;
        end else begin
            attack_valid <= 1'b0;
            attack_slot  <= 2'd0;
            attack_dmg   <= 8'd0;
            if ((state == DAMAGE) && win_found) begin
                attack_valid <= 1'b1;
                attack_slot  <= win_idx;
                attack_dmg   <= win_dmg;
                rr           <= win_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler: a vector table of whole tick
// sequences plus hand-written timing, overrun, wave and reset sequences.
module tb_enemy_spawn_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_tick;
    logic        enable;
    logic [3:0]  slot_alive;
    logic [31:0] slot_damage;
    logic [3:0]  spawn_req;
    logic        move_scen;
    logic        damage_scen;
    logic        attack_valid;
    logic [1:0]  attack_slot;
    logic [7:0]  attack_dmg;
    logic [7:0]  wave_num;
    logic        busy;
    logic        overrun;

    int n_cmp = 0;
    int n_bad = 0;

    enemy_spawn_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .game_tick    (game_tick),
        .enable       (enable),
        .slot_alive   (slot_alive),
        .slot_damage  (slot_damage),
        .spawn_req    (spawn_req),
        .move_scen    (move_scen),
        .damage_scen  (damage_scen),
        .attack_valid (attack_valid),
        .attack_slot  (attack_slot),
        .attack_dmg   (attack_dmg),
        .wave_num     (wave_num),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  alive;
        logic [31:0] dmg;
        logic [3:0]  exp_spawn;
        logic        exp_av;
        logic [1:0]  exp_slot;
        logic [7:0]  exp_adm;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic [3:0] alive, input logic [31:0] dmg,
                                input logic [3:0] sp, input logic av,
                                input logic [1:0] sl, input logic [7:0] ad);
        vec_t v;
        v.alive = alive; v.dmg = dmg; v.exp_spawn = sp;
        v.exp_av = av; v.exp_slot = sl; v.exp_adm = ad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One accepted tick; returns spawn_req at T+1, attack outputs at T+4 and
    // attack_valid at T+5. Leaves the bench at T+5, ready for the next tick.
    task automatic run_tick(output logic [3:0] sreq, output logic av,
                            output logic [1:0] aslot, output logic [7:0] admg,
                            output logic av_after);
        game_tick = 1'b1;
        adv();
        game_tick = 1'b0;
        sreq = spawn_req;
        adv();
        adv();
        adv();
        av    = attack_valid;
        aslot = attack_slot;
        admg  = attack_dmg;
        adv();
        av_after = attack_valid;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " spawn_req"},    32'(spawn_req),    32'h0);
        check({tag, " move_scen"},    32'(move_scen),    32'h0);
        check({tag, " damage_scen"},  32'(damage_scen),  32'h0);
        check({tag, " attack_valid"}, 32'(attack_valid), 32'h0);
        check({tag, " attack_slot"},  32'(attack_slot),  32'h0);
        check({tag, " attack_dmg"},   32'(attack_dmg),   32'h0);
        check({tag, " wave_num"},     32'(wave_num),     32'h0);
        check({tag, " busy"},         32'(busy),         32'h0);
        check({tag, " overrun"},      32'(overrun),      32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] sreq;
        logic       av;
        logic       av_after;
        logic [1:0] aslot;
        logic [7:0] admg;
        int         spawns;
        int         since;
        int         ticks;
        int         exp_int;

        reset       = 1'b1;
        game_tick   = 1'b0;
        enable      = 1'b1;
        slot_alive  = 4'b0000;
        slot_damage = 32'h0;

        // Reset state
        adv();
        adv();
        check_all_zero("reset");
        reset = 1'b0;
        adv();

        // Vector table: each row is one full tick sequence, applied in order.
        for (int i = 0; i < 7; i++) vecs[i] = mk(4'b0000, 32'h0, 4'b0000, 1'b0, 2'd0, 8'h00);
        vecs[7] = mk(4'b0000, 32'h0, 4'b0001, 1'b0, 2'd0, 8'h00);
        for (int i = 8; i < 16; i++) vecs[i] = mk(4'b1111, 32'h0, 4'b0000, 1'b0, 2'd0, 8'h00);
        vecs[16] = mk(4'b1011, 32'h0,         4'b0100, 1'b0, 2'd0, 8'h00);
        vecs[17] = mk(4'b0101, 32'h0020_0020, 4'b0000, 1'b1, 2'd0, 8'h20);
        vecs[18] = mk(4'b0101, 32'h0020_0020, 4'b0000, 1'b1, 2'd2, 8'h20);
        vecs[19] = mk(4'b0101, 32'h0020_0020, 4'b0000, 1'b1, 2'd0, 8'h20);
        vecs[20] = mk(4'b0000, 32'hFF00_0000, 4'b0000, 1'b0, 2'd0, 8'h00);
        vecs[21] = mk(4'b1000, 32'hFF00_0000, 4'b0000, 1'b1, 2'd3, 8'hFF);
        vecs[22] = mk(4'b0000, 32'h0,         4'b0000, 1'b0, 2'd0, 8'h00);
        vecs[23] = mk(4'b0000, 32'h0,         4'b0000, 1'b0, 2'd0, 8'h00);
        vecs[24] = mk(4'b0110, 32'h0000_0500, 4'b0001, 1'b1, 2'd1, 8'h05);

        for (int i = 0; i < 25; i++) begin
            slot_alive  = vecs[i].alive;
            slot_damage = vecs[i].dmg;
            run_tick(sreq, av, aslot, admg, av_after);
            check($sformatf("vec%0d spawn_req", i),    32'(sreq),     32'(vecs[i].exp_spawn));
            check($sformatf("vec%0d attack_valid", i), 32'(av),       32'(vecs[i].exp_av));
            check($sformatf("vec%0d attack_slot", i),  32'(aslot),    32'(vecs[i].exp_slot));
            check($sformatf("vec%0d attack_dmg", i),   32'(admg),     32'(vecs[i].exp_adm));
            check($sformatf("vec%0d attack_end", i),   32'(av_after), 32'h0);
        end

        // Timing, enable and overrun
        do_reset();
        slot_alive  = 4'b0000;
        slot_damage = 32'h0;
        enable      = 1'b0;
        game_tick   = 1'b1;
        adv();
        game_tick = 1'b0;
        check("disabled tick busy", 32'(busy), 32'h0);
        enable    = 1'b1;
        game_tick = 1'b1;
        adv();
        game_tick = 1'b0;
        enable    = 1'b0;
        check("T+1 busy", 32'(busy), 32'h1);
        check("T+1 move_scen", 32'(move_scen), 32'h0);
        adv();
        enable = 1'b1;
        check("T+2 busy", 32'(busy), 32'h1);
        check("T+2 move_scen", 32'(move_scen), 32'h1);
        check("T+2 damage_scen", 32'(damage_scen), 32'h0);
        check("T+2 overrun", 32'(overrun), 32'h0);
        game_tick = 1'b1;
        adv();
        game_tick = 1'b0;
        check("T+3 busy", 32'(busy), 32'h1);
        check("T+3 move_scen", 32'(move_scen), 32'h0);
        check("T+3 damage_scen", 32'(damage_scen), 32'h1);
        check("T+3 overrun", 32'(overrun), 32'h1);
        adv();
        check("T+4 busy", 32'(busy), 32'h1);
        check("T+4 damage_scen", 32'(damage_scen), 32'h0);
        adv();
        check("T+5 busy", 32'(busy), 32'h0);
        adv();
        adv();
        check("overrun sticky", 32'(overrun), 32'h1);
        // Only one tick was accepted so far: the 7th further tick spawns.
        for (int i = 2; i <= 8; i++) begin
            run_tick(sreq, av, aslot, admg, av_after);
            check($sformatf("count tick%0d spawn_req", i), 32'(sreq),
                  (i == 8) ? 32'h1 : 32'h0);
        end

        // Wave progression and period floor
        do_reset();
        slot_alive  = 4'b0000;
        slot_damage = 32'h0;
        spawns = 0;
        since  = 0;
        ticks  = 0;
        while (spawns < 32 && ticks < 400) begin
            run_tick(sreq, av, aslot, admg, av_after);
            ticks++;
            since++;
            if (sreq != 4'b0000) begin
                spawns++;
                exp_int = (spawns == 1) ? 8 : 8 - (spawns - 2) / 4;
                if (exp_int < 2) exp_int = 2;
                check($sformatf("spawn%0d slot", spawns), 32'(sreq), 32'h1);
                check($sformatf("spawn%0d interval", spawns), since, exp_int);
                check($sformatf("spawn%0d wave_num", spawns), 32'(wave_num), spawns / 4);
                since = 0;
            end
        end
        if (spawns < 32) check("wave tick budget", spawns, 32);

        // Reset during DAMAGE, from a non-zero wave
        slot_alive  = 4'b0001;
        slot_damage = 32'h0000_0020;
        game_tick   = 1'b1;
        adv();
        game_tick = 1'b0;
        adv();
        adv();
        check("pre-reset damage_scen", 32'(damage_scen), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid reset");
        adv();
        check("reset attack_valid", 32'(attack_valid), 32'h0);
        reset = 1'b0;
        adv();
        slot_alive  = 4'b0000;
        slot_damage = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            run_tick(sreq, av, aslot, admg, av_after);
            check($sformatf("restart tick%0d spawn_req", i), 32'(sreq),
                  (i == 8) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enemy_spawn_scheduler.md
ENEMY_SPAWN_SCHEDULER -- requirements
Module: enemy_spawn_scheduler

Interface
REQ-001 Parameter SPAWN_PERIOD, default 8: initial number of accepted game ticks between spawns.
REQ-002 Parameter MIN_PERIOD, default 2: floor for the spawn period.
REQ-003 Parameter WAVE_SIZE, default 4: number of spawns per wave.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port game_tick  input  1  one-clk pulse per game step.
REQ-007 Port enable  input  1  when high, game ticks are accepted.
REQ-008 Port slot_alive  input  4  per-enemy-slot alive flag.
REQ-009 Port slot_damage  input  32  per-slot damageOut; slot i occupies bits [8i+7:8i].
REQ-010 Port spawn_req  output  4  one-hot, one-cycle deploy pulse to a slot.
REQ-011 Port move_scen  output  1  one-cycle move strobe to all slots.
REQ-012 Port damage_scen  output  1  one-cycle damage-apply strobe to all slots.
REQ-013 Port attack_valid  output  1  one-cycle pulse marking a granted enemy attack.
REQ-014 Port attack_slot  output  2  index of the granted slot.
REQ-015 Port attack_dmg  output  8  damage value of the granted slot.
REQ-016 Port wave_num  output  8  current wave number.
REQ-017 Port busy  output  1  high while a tick sequence is in progress.
REQ-018 Port overrun  output  1  sticky flag: a tick arrived while busy.

Function
REQ-019 The FSM SHALL have states IDLE, SPAWN, MOVE, DAMAGE and ATTACK, each lasting exactly one cycle except IDLE.
REQ-020 A tick in IDLE with enable=1 is accepted: the edge ending tick cycle T enters SPAWN; MOVE at T+2, DAMAGE at T+3, ATTACK at T+4, IDLE at T+5.
REQ-021 busy SHALL be high during T+1..T+4 and low in IDLE.
REQ-022 Ticks in IDLE with enable=0 SHALL be ignored; enable falling mid-sequence SHALL NOT abort the sequence.
REQ-023 A tick while busy SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-024 Spawn counter cnt (8 bits) and current period per (8 bits): on an accepted tick, if cnt<=1 a spawn is due, otherwise cnt decrements.
REQ-025 When a spawn is due, free slot = lowest index with slot_alive=0, sampled at acceptance; spawn_req SHALL be high for that bit only during T+1; cnt reloads to per.
REQ-026 When a spawn is due and no slot is free, no spawn_req SHALL fire, cnt SHALL be set to 0, and the spawn is retried on the next accepted tick.
REQ-027 A 3-bit spawn count SHALL increment per spawn; on reaching WAVE_SIZE it SHALL clear, wave_num SHALL increment (saturating at 255), and per SHALL decrement (not below MIN_PERIOD); a new per takes effect at the next reload.
REQ-028 move_scen SHALL be high during T+2 only; damage_scen SHALL be high during T+3 only.
REQ-029 Attack arbitration: on the edge ending T+3, candidates are slots with slot_alive=1 and nonzero damage; round-robin search starts at 2-bit pointer rr, ascending, wrapping 3->0.
REQ-030 When a candidate exists, attack_valid=1, attack_slot=winner and attack_dmg=winner's damage SHALL hold during T+4 only; rr becomes winner+1 mod 4.
REQ-031 With no candidate, attack_valid SHALL stay 0, attack_slot and attack_dmg SHALL be 0, and rr SHALL be unchanged.
REQ-032 attack_slot and attack_dmg SHALL be 0 whenever attack_valid=0.

Reset
REQ-033 Reset SHALL force, immediately and also mid-sequence: state IDLE; all strobes, busy, overrun, attack outputs and wave_num to 0; cnt=SPAWN_PERIOD; per=SPAWN_PERIOD; spawn count 0; rr 0.
REQ-034 The first accepted tick after reset release SHALL be processed normally.

Verification
REQ-035 Defaults, slot_alive=0000, 8 accepted ticks -> no spawn_req on ticks 1-7; spawn_req=0001 for one cycle on tick 8.
REQ-036 slot_alive=1111 when a spawn is due -> no spawn_req; slot_alive=1011 on the next tick -> spawn_req=0100.
REQ-037 Single tick -> busy for 4 cycles, then move_scen at T+2 and damage_scen at T+3 as one-cycle pulses; second tick at T+2 -> ignored, overrun=1.
REQ-038 Slots 0 and 2 alive, damage 0x20 each, three sequences -> attack_slot 0, 2, 0 with attack_dmg=0x20 each.
REQ-039 Four spawns -> wave_num=1, next reload period 7; continue to per=2, then further waves keep per=2.
REQ-040 Reset asserted during DAMAGE -> all outputs 0 at once, no attack_valid; after release, the spawn counter restarts at 8.
